// File: rtl/fifo_vc_if.sv
// Handshake/data bundle between a virtual-channel FIFO and its producer/consumer.
// The master side drives push/pop/data_in; the slave side (the FIFO) returns data and flags.
interface fifo_vc_if #(
  parameter int BITNUMBER = 5
);
  logic                 push;
  logic [BITNUMBER-1:0] data_in;
  logic                 pop;
  logic [BITNUMBER-1:0] data_out;
  logic                 valid_out;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 error;

  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty, error
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty, error
  );
endinterface

// File: rtl/fifo_vc.sv
// Virtual-channel FIFO: registered read data one cycle after an accepted pop.
// Push at full is accepted only alongside a real pop; overflow/underflow set a sticky error.
module fifo_vc #(
  parameter int BITNUMBER = 5,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PTR_WIDTH:0]   umbral_alto,
  input  logic [PTR_WIDTH:0]   umbral_bajo,
  fifo_vc_if.slave             bus
);

  localparam logic [PTR_WIDTH:0]   FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);

  logic [BITNUMBER-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH:0]   count;
  logic [PTR_WIDTH:0]   umbral_alto_reg;
  logic [PTR_WIDTH:0]   umbral_bajo_reg;
  logic                 pop_ok;
  logic                 push_ok;
  logic                 overflow;
  logic                 underflow;

  assign pop_ok    = bus.pop && (count != '0);
  // A full FIFO still takes a push when a pop frees a slot on the same edge.
  assign push_ok   = bus.push && ((count != FULL_CNT) || pop_ok);
  assign overflow  = bus.push && !push_ok;
  assign underflow = bus.pop && (count == '0);

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      bus.data_out    <= '0;
      bus.valid_out   <= 1'b0;
      bus.error       <= 1'b0;
      umbral_alto_reg <= umbral_alto;
      umbral_bajo_reg <= umbral_bajo;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        bus.data_out  <= mem[rd_ptr];
        bus.valid_out <= 1'b1;
        rd_ptr        <= rd_ptr + PTR_ONE;
      end else begin
        bus.valid_out <= 1'b0;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (overflow || underflow) begin
        bus.error <= 1'b1;
      end
    end
  end

  assign bus.empty        = (count == '0);
  assign bus.full         = (count == FULL_CNT);
  assign bus.almost_full  = (count >= umbral_alto_reg);
  assign bus.almost_empty = (count <= umbral_bajo_reg);

endmodule

// File: doc/fifo_vc.md
# fifo_vc

Virtual-channel FIFO that buffers words for one virtual channel and presents them, one per pop, as a `valid`/`data` pair. Two instances (VC0, VC1) sit directly upstream of `mux_dest` and drive its `valid_VC0`/`data_in0` and `valid_VC1`/`data_in1` inputs. It also supplies the occupancy flags the arbiter and the flow-control logic use.

## Interface
- `BITNUMBER`, 5: word width; matches `mux_dest` data width.
- `DEPTH`, 4: entries; power of two, ≥ 2.
- `PTR_WIDTH`, 2: log2(DEPTH); count width is PTR_WIDTH+1.

- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `umbral_alto`  in  PTR_WIDTH+1  almost-full threshold; sampled only while `reset`=1.
- `umbral_bajo`  in  PTR_WIDTH+1  almost-empty threshold; sampled only while `reset`=1.
- `push`  in  1  write request.
- `data_in`  in  BITNUMBER  write data.
- `pop`  in  1  read request.
- `data_out`  out  BITNUMBER  registered read data; to `mux_dest` `data_inN`.
- `valid_out`  out  1  registered; 1 when `data_out` holds a popped word; to `mux_dest` `valid_VCN`.
- `full`, `empty`  out  1 each  occupancy flags.
- `almost_full`, `almost_empty`  out  1 each  threshold flags.
- `error`  out  1  sticky overflow/underflow indicator.

## Operation
- Storage: DEPTH×BITNUMBER register array, write pointer `wr_ptr`, read pointer `rd_ptr` (PTR_WIDTH bits each, wrap modulo DEPTH), `count` (0..DEPTH).
- While `reset`=1 (every cycle): `wr_ptr`, `rd_ptr` and `count` cleared to 0; `data_out` and `valid_out` cleared to 0; `error` cleared to 0; `umbral_alto` and `umbral_bajo` captured into internal registers. Array contents are don't-care.
- Push accepted iff `push`=1 and (count<DEPTH, or `pop` accepted in the same cycle). On accept: mem[wr_ptr]←data_in, wr_ptr+1.
- Pop accepted iff `pop`=1 and count>0. On accept: data_out←mem[rd_ptr], valid_out←1, rd_ptr+1. Otherwise valid_out←0 and data_out holds its value.
- Count update: +1 for push only, −1 for pop only, unchanged for both or neither.
- Overflow: `push` while full and no accepted pop → word dropped, pointers unchanged, `error`←1.
- Underflow: `pop` while count=0 → ignored, valid_out←0, `error`←1. A simultaneous push is still accepted; the pushed word is not bypassed to the output.
- `error` stays 1 until reset.
- Flags are combinational from `count` and the captured thresholds:
  - empty = (count==0)
  - full = (count==DEPTH)
  - almost_full = (count ≥ umbral_alto_reg)
  - almost_empty = (count ≤ umbral_bajo_reg)

## Timing
- Reset values: data_out=0, valid_out=0, error=0, empty=1, full=0, almost_full=0 (given umbral_alto_reg>0), almost_empty=1.
- Read latency is 1 cycle: pop sampled at edge N gives `data_out`/`valid_out` during cycle N+1. Back-to-back pops produce one word per cycle.
- Write-to-read latency: a word pushed at edge N may be popped at edge N+1, so it appears at `data_out` after edge N+1.
- Flags reflect `count` after each edge; there is no lookahead.
- Reset asserted mid-stream: at the next edge the FIFO empties and `valid_out` drops. Words in flight are lost.
- Pointer wrap: after the pointer reaches DEPTH−1 it goes to 0 with no bubble.

## Test plan
- Reset with umbral_alto=3, umbral_bajo=1 → after the reset edge: empty=1, almost_empty=1, full=0, almost_full=0, valid_out=0, data_out=0, error=0.
- Push 5'h01, 5'h02, 5'h03, 5'h04 on consecutive cycles → full=1 after the 4th edge, almost_full=1 after the 3rd; then 4 pops → data_out 01, 02, 03, 04 on consecutive cycles with valid_out=1, then empty=1.
- At full, push 5'h1F with no pop → word dropped, error=1 and stays 1; a subsequent drain returns only the original 4 words.
- At full, push 5'h10 and pop together → data_out=oldest word, count stays 4, error unchanged; the 5'h10 word emerges 4 pops later.
- From empty, pop alone → valid_out=0, error=1. From empty, push+pop together → push accepted, valid_out=0, count=1.
- 10 push/pop pairs with a steady count of 2 → pointers wrap; the output order matches the input order exactly. Reset mid-stream → next cycle empty=1, valid_out=0, error=0.
